// File: rtl/trisc_datapath.sv
`default_nettype none
// ============================================================================
// Module      : trisc_datapath
// Description : Controlled datapath driven by the trisc sequencer's control
//               word. Executes an 8-bit accumulator operation, an optional
//               8-bit loop counter operation and two valid/ready stream
//               handshakes every cycle. Returns condition flags to the
//               sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous, active-high reset
//   ctrl       in   OW  control word from the sequencer
//   flags      out  CW  condition bits to the sequencer
//   in_valid   in   1   input stream data valid
//   in_data    in   8   input stream data
//   in_ready   out  1   input stream ready (combinational)
//   out_valid  out  1   output holding register full
//   out_data   out  8   output holding register contents
//   out_ready  in   1   downstream accepts out_data
//   err        out  1   sticky flag for a dropped output push
// ----------------------------------------------------------------------------
// Configuration
//   TRISC_DP_LOOPCNT_EN  defined   : 8-bit loop counter is built.
//                        undefined : counter removed, cnt_op ignored,
//                                    flags[2] tied to 1.
// ----------------------------------------------------------------------------
// Control word
//   [3:0]   acc_op   [11:4] imm   [13:12] cnt_op   [14] out_push
//   [15]    ovf_clr  [16]   err_clr              [OW-1:17] reserved
// ============================================================================
module trisc_datapath #(
    parameter int CW = 7,
    parameter int OW = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [OW-1:0] ctrl,
    output logic [CW-1:0] flags,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          err
);

    // Accumulator operation encodings
    localparam logic [3:0] C_OP_NOP  = 4'd0;
    localparam logic [3:0] C_OP_LDI  = 4'd1;
    localparam logic [3:0] C_OP_ADDI = 4'd2;
    localparam logic [3:0] C_OP_SUBI = 4'd3;
    localparam logic [3:0] C_OP_SHL  = 4'd4;
    localparam logic [3:0] C_OP_SHR  = 4'd5;
    localparam logic [3:0] C_OP_CLR  = 4'd6;
    localparam logic [3:0] C_OP_LDIN = 4'd7;
    localparam logic [3:0] C_OP_ANDI = 4'd8;
    localparam logic [3:0] C_OP_XORI = 4'd9;

`ifdef TRISC_DP_LOOPCNT_EN
    // Counter operation encodings
    localparam logic [1:0] C_CNT_HOLD = 2'd0;
    localparam logic [1:0] C_CNT_LDI  = 2'd1;
    localparam logic [1:0] C_CNT_DEC  = 2'd2;
    localparam logic [1:0] C_CNT_CLR  = 2'd3;
`endif

    // ------------------------------------------------------------------------
    // Control word field decode
    // ------------------------------------------------------------------------
    logic [3:0] w_acc_op;
    logic [7:0] w_imm;
    logic       w_out_push;
    logic       w_ovf_clr;
    logic       w_err_clr;

    assign w_acc_op   = ctrl[3:0];
    assign w_imm      = ctrl[11:4];
    assign w_out_push = ctrl[14];
    assign w_ovf_clr  = ctrl[15];
    assign w_err_clr  = ctrl[16];

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [7:0] r_acc;
    logic       r_ovf;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic       r_err;
    logic       w_cnt_zero;

    // ------------------------------------------------------------------------
    // Input handshake. Ready is withheld during reset so no transfer can be
    // reported to the upstream source while the datapath ignores ctrl.
    // ------------------------------------------------------------------------
    logic w_in_xfer;

    assign in_ready  = (w_acc_op == C_OP_LDIN) && !reset;
    assign w_in_xfer = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Accumulator next-state and overflow detection. The 9-bit sum/difference
    // carry the carry-out / borrow in bit 8.
    // ------------------------------------------------------------------------
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_acc_next;
    logic       w_ovf_set;

    assign w_sum  = {1'b0, r_acc} + {1'b0, w_imm};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_imm};

    always_comb begin
        w_acc_next = r_acc;
        w_ovf_set  = 1'b0;
        case (w_acc_op)
            C_OP_NOP:  w_acc_next = r_acc;
            C_OP_LDI:  w_acc_next = w_imm;
            C_OP_ADDI: begin
                w_acc_next = w_sum[7:0];
                w_ovf_set  = w_sum[8];
            end
            C_OP_SUBI: begin
                w_acc_next = w_diff[7:0];
                w_ovf_set  = w_diff[8];
            end
            C_OP_SHL:  w_acc_next = {r_acc[6:0], 1'b0};
            C_OP_SHR:  w_acc_next = {1'b0, r_acc[7:1]};
            C_OP_CLR:  w_acc_next = 8'h00;
            C_OP_LDIN: begin
                if (w_in_xfer) begin
                    w_acc_next = in_data;
                end
            end
            C_OP_ANDI: w_acc_next = r_acc & w_imm;
            C_OP_XORI: w_acc_next = r_acc ^ w_imm;
            default:   w_acc_next = r_acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= 8'h00;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            // A new overflow in the same cycle as a clear must not be lost.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output holding register. A drain frees the slot in the same cycle, so a
    // push alongside a drain is accepted back-to-back. The pushed value is
    // the accumulator before this cycle's acc_op takes effect.
    // ------------------------------------------------------------------------
    logic w_drain;
    logic w_push_ok;
    logic w_push_drop;

    assign w_drain     = r_out_valid && out_ready;
    assign w_push_ok   = w_out_push && (!r_out_valid || w_drain);
    assign w_push_drop = w_out_push && r_out_valid && !w_drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_acc;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            // A dropped push in the same cycle as a clear keeps err set.
            if (w_push_drop) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Loop counter (optional). Decrement saturates at zero so a loop exit
    // condition, once reached, stays reached.
    // ------------------------------------------------------------------------
`ifdef TRISC_DP_LOOPCNT_EN
    logic [1:0] w_cnt_op;
    logic [7:0] r_cnt;

    assign w_cnt_op = ctrl[13:12];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 8'h00;
        end else begin
            case (w_cnt_op)
                C_CNT_HOLD: r_cnt <= r_cnt;
                C_CNT_LDI:  r_cnt <= w_imm;
                C_CNT_DEC:  r_cnt <= (r_cnt == 8'h00) ? 8'h00 : r_cnt - 8'd1;
                C_CNT_CLR:  r_cnt <= 8'h00;
                default:    r_cnt <= r_cnt;
            endcase
        end
    end

    assign w_cnt_zero = (r_cnt == 8'h00);

    // Reserved control bits carry no function.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^ctrl[OW-1:17];
`else
    // Without the counter every counted loop terminates after one pass.
    assign w_cnt_zero = 1'b1;

    // Reserved bits and cnt_op carry no function in this build.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{ctrl[OW-1:17], ctrl[13:12]};
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign err       = r_err;

    assign flags[0] = (r_acc == 8'h00);
    assign flags[1] = r_acc[7];
    assign flags[2] = w_cnt_zero;
    assign flags[3] = in_valid;
    assign flags[4] = !r_out_valid;
    assign flags[5] = r_ovf;
    assign flags[6] = 1'b1;

endmodule
`default_nettype wire
